cansec_rx_verify: RTL



---
 rtl/cansec_rx_verify_pkg.sv | 27 ++
 rtl/cansec_rx_verify_if.sv | 39 +++
 rtl/cansec_rx_verify_fv_table.sv | 51 +++++
 rtl/cansec_rx_verify.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cansec_rx_verify_pkg.sv
// Shared types for the CAN-SEC receive verifier: result codes, FSM states
// and the result-priority helper.
package cansec_pkg;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_FRESH   = 2'd1;
  localparam logic [1:0] ERR_ICV     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ICV,
    RESULT,
    COMMIT
  } state_e;

  // Engine timeout masks everything; a stale FV is reported ahead of a bad ICV.
  function automatic logic [1:0] pick_err(input logic timeout,
                                          input logic fresh_ok,
                                          input logic icv_ok);
    if (timeout)       return ERR_TIMEOUT;
    else if (!fresh_ok) return ERR_FRESH;
    else if (!icv_ok)   return ERR_ICV;
    else                return ERR_OK;
  endfunction

endpackage

// File: rtl/cansec_rx_verify_if.sv
// Frame-parser / ICV-engine / CAN-layer bundle seen by the receive verifier.
interface cansec_rx_verify_if #(
  parameter int NUM_CH = 4,
  parameter int ICV_W  = 128,
  parameter int FV_W   = 32
);
  localparam int CH_W = $clog2(NUM_CH);

  logic             frm_valid;
  logic             frm_sec;
  logic [CH_W-1:0]  frm_ch;
  logic [FV_W-1:0]  frm_fv;
  logic [ICV_W-1:0] frm_icv;
  logic             calc_valid;
  logic [ICV_W-1:0] calc_icv;
  logic             rx_success;
  logic             rx_abort;
  logic             ch_clear;
  logic [CH_W-1:0]  ch_clear_idx;
  logic             busy;
  logic             verify_done;
  logic             security_err;
  logic [1:0]       err_code;
  logic             fv_commit;
  logic [FV_W-1:0]  fv_out;
  logic             overrun;

  modport master (
    output frm_valid, frm_sec, frm_ch, frm_fv, frm_icv, calc_valid, calc_icv,
           rx_success, rx_abort, ch_clear, ch_clear_idx,
    input  busy, verify_done, security_err, err_code, fv_commit, fv_out, overrun
  );

  modport slave (
    input  frm_valid, frm_sec, frm_ch, frm_fv, frm_icv, calc_valid, calc_icv,
           rx_success, rx_abort, ch_clear, ch_clear_idx,
    output busy, verify_done, security_err, err_code, fv_commit, fv_out, overrun
  );
endinterface

// File: rtl/cansec_rx_verify_fv_table.sv
// Per-channel last-accepted freshness value plus "seen" flag; combinational
// read, one write port, one clear port (clear wins on the same channel).
module cansec_fv_table #(
  parameter int NUM_CH = 4,
  parameter int FV_W   = 32,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic            clk,
  input  logic            g_rst,
  input  logic [CH_W-1:0] rd_idx,
  output logic [FV_W-1:0] rd_fv,
  output logic            rd_seen,
  input  logic            we,
  input  logic [CH_W-1:0] wr_idx,
  input  logic [FV_W-1:0] wr_fv,
  input  logic            clr,
  input  logic [CH_W-1:0] clr_idx
);

  logic [FV_W-1:0]   fv_q   [NUM_CH];
  logic [FV_W-1:0]   fv_d   [NUM_CH];
  logic [NUM_CH-1:0] seen_q;
  logic [NUM_CH-1:0] seen_d;

  always_comb begin
    fv_d   = fv_q;
    seen_d = seen_q;
    if (we) begin
      fv_d[wr_idx]   = wr_fv;
      seen_d[wr_idx] = 1'b1;
    end
    if (clr) begin
      fv_d[clr_idx]   = '0;
      seen_d[clr_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      for (int i = 0; i < NUM_CH; i++) fv_q[i] <= '0;
      seen_q <= '0;
    end else begin
      fv_q   <= fv_d;
      seen_q <= seen_d;
    end
  end

  assign rd_fv   = fv_q[rd_idx];
  assign rd_seen = seen_q[rd_idx];

endmodule

// File: rtl/cansec_rx_verify.sv
// CAN-SEC receive verifier: freshness window check, ICV compare with engine
// timeout, and FV commit once the CAN layer confirms reception.
module cansec_rx_verify
  import cansec_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ICV_W       = 128,
  parameter int FV_W        = 32,
  parameter int MAX_GAP     = 1024,
  parameter int TIMEOUT_CYC = 256
) (
  input logic               clk,
  input logic               g_rst,
  cansec_rx_verify_if.slave bus
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [FV_W-1:0]  MAX_GAP_V = FV_W'(MAX_GAP);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fresh_ok_q, fresh_ok_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [FV_W-1:0]  fv_q, fv_d;
  logic [ICV_W-1:0] icv_q, icv_d;
  logic             verify_done_q, verify_done_d;
  logic             security_err_q, security_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             fv_commit_q, fv_commit_d;
  logic [FV_W-1:0]  fv_out_q, fv_out_d;
  logic             overrun_q, overrun_d;

  logic [FV_W-1:0]  tbl_rd_fv;
  logic             tbl_rd_seen;
  logic             tbl_we;
  logic [FV_W-1:0]  fv_gap;
  logic             fresh_now;
  logic [1:0]       err_sel;

  cansec_fv_table #(.NUM_CH(NUM_CH), .FV_W(FV_W)) u_fv_table (
    .clk     (clk),
    .g_rst   (g_rst),
    .rd_idx  (bus.frm_ch),
    .rd_fv   (tbl_rd_fv),
    .rd_seen (tbl_rd_seen),
    .we      (tbl_we),
    .wr_idx  (ch_q),
    .wr_fv   (fv_q),
    .clr     (bus.ch_clear),
    .clr_idx (bus.ch_clear_idx)
  );

  // Forward-only window, no wrap: an all-ones history locks the channel out.
  assign fv_gap    = bus.frm_fv - tbl_rd_fv;
  assign fresh_now = !tbl_rd_seen || ((bus.frm_fv > tbl_rd_fv) && (fv_gap <= MAX_GAP_V));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fresh_ok_d     = fresh_ok_q;
    ch_d           = ch_q;
    fv_d           = fv_q;
    icv_d          = icv_q;
    verify_done_d  = 1'b0;
    security_err_d = 1'b0;
    err_code_d     = ERR_OK;
    fv_commit_d    = 1'b0;
    fv_out_d       = fv_out_q;
    overrun_d      = 1'b0;
    tbl_we         = 1'b0;
    err_sel        = ERR_OK;

    case (state_q)
      IDLE: begin
        if (bus.frm_valid) begin
          if (bus.frm_sec) begin
            ch_d       = bus.frm_ch;
            fv_d       = bus.frm_fv;
            icv_d      = bus.frm_icv;
            fresh_ok_d = fresh_now;
            cnt_d      = '0;
            state_d    = WAIT_ICV;
          end else begin
            verify_done_d = 1'b1;
          end
        end
      end
      WAIT_ICV: begin
        overrun_d = bus.frm_valid;
        if (bus.rx_abort) begin
          state_d = IDLE;
        end else if (bus.calc_valid || (cnt_q == CNT_LAST)) begin
          err_sel        = pick_err(!bus.calc_valid, fresh_ok_q, bus.calc_icv == icv_q);
          verify_done_d  = 1'b1;
          err_code_d     = err_sel;
          security_err_d = (err_sel != ERR_OK);
          state_d        = RESULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESULT: begin
        overrun_d = bus.frm_valid;
        state_d   = (err_code_q == ERR_OK) ? COMMIT : IDLE;
      end
      COMMIT: begin
        overrun_d = bus.frm_valid;
        if (bus.rx_abort) begin
          state_d = IDLE;
        end else if (bus.rx_success) begin
          state_d = IDLE;
          // A rekey landing on the same channel discards this commit.
          if (!(bus.ch_clear && (bus.ch_clear_idx == ch_q))) begin
            tbl_we      = 1'b1;
            fv_commit_d = 1'b1;
            fv_out_d    = fv_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      fresh_ok_q     <= 1'b0;
      verify_done_q  <= 1'b0;
      security_err_q <= 1'b0;
      err_code_q     <= ERR_OK;
      fv_commit_q    <= 1'b0;
      fv_out_q       <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fresh_ok_q     <= fresh_ok_d;
      verify_done_q  <= verify_done_d;
      security_err_q <= security_err_d;
      err_code_q     <= err_code_d;
      fv_commit_q    <= fv_commit_d;
      fv_out_q       <= fv_out_d;
      overrun_q      <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    ch_q  <= ch_d;
    fv_q  <= fv_d;
    icv_q <= icv_d;
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.verify_done  = verify_done_q;
  assign bus.security_err = security_err_q;
  assign bus.err_code     = err_code_q;
  assign bus.fv_commit    = fv_commit_q;
  assign bus.fv_out       = fv_out_q;
  assign bus.overrun      = overrun_q;

endmodule
